// File: rtl/aes_cmd_sequencer.sv
// Command sequencer between the UART byte link and AES_top: parses K/E/D frames,
// drives key load / encrypt / decrypt requests and serialises the response bytes.
module aes_cmd_sequencer #(
  parameter int unsigned IN_VALID_CYCLES = 2,
  parameter int unsigned RX_TIMEOUT      = 1_000_000,
  parameter int unsigned AES_TIMEOUT     = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_dv,
  input  logic [7:0]   rx_byte,
  output logic         tx_dv,
  output logic [7:0]   tx_byte,
  input  logic         tx_done,
  output logic         load_new_key,
  output logic [127:0] cipher_key,
  output logic         enc_in_valid,
  output logic         dec_in_valid,
  output logic [127:0] aes_data_in,
  input  logic         enc_out_valid,
  input  logic [127:0] cipher_text_out,
  input  logic         dec_out_valid,
  input  logic [127:0] plain_text_out,
  input  logic         done_key_expansion,
  output logic         key_valid,
  output logic         busy,
  output logic         err
);

  localparam int RXW  = $clog2(RX_TIMEOUT + 1);
  localparam int AESW = $clog2(AES_TIMEOUT + 1);
  localparam logic [RXW-1:0]  RX_LAST  = RXW'(RX_TIMEOUT - 1);
  localparam logic [AESW-1:0] AES_LAST = AESW'(AES_TIMEOUT);
  localparam logic [AESW-1:0] KEY_SKIP = AESW'(3);
  localparam logic [3:0]      IV_LAST  = 4'(IN_VALID_CYCLES - 1);

  localparam logic [7:0] OP_K = 8'h4B;
  localparam logic [7:0] OP_E = 8'h45;
  localparam logic [7:0] OP_D = 8'h44;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  typedef enum logic [3:0] {
    IDLE, RX_DATA, LOAD_KEY, WAIT_KEY, ISSUE, WAIT_RES,
    TX_BYTE, TX_WAIT, SEND_ACK, SEND_NAK, WAIT_1
  } state_t;

  state_t          state_q;
  logic [7:0]      op_q;
  logic [3:0]      cnt_q;
  logic [RXW-1:0]  rx_tmr_q;
  logic [AESW-1:0] aes_tmr_q;
  logic [127:0]    shreg_q;
  logic [127:0]    key_q;
  logic [127:0]    data_q;
  logic [7:0]      tx_byte_q;
  logic            tx_dv_q, lnk_q, enc_iv_q, dec_iv_q, key_valid_q, err_q;
  logic            res_hit;

  assign res_hit = (op_q == OP_E) ? enc_out_valid : dec_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      rx_tmr_q    <= '0;
      aes_tmr_q   <= '0;
      shreg_q     <= '0;
      key_q       <= '0;
      data_q      <= '0;
      tx_byte_q   <= '0;
      tx_dv_q     <= 1'b0;
      lnk_q       <= 1'b0;
      enc_iv_q    <= 1'b0;
      dec_iv_q    <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tx_dv_q  <= 1'b0;
      lnk_q    <= 1'b0;
      enc_iv_q <= 1'b0;
      dec_iv_q <= 1'b0;

      // Bytes arriving while a command is in flight are dropped and flagged.
      if (rx_dv && (state_q != IDLE) && (state_q != RX_DATA)) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (rx_dv) begin
            if (rx_byte == OP_K || rx_byte == OP_E || rx_byte == OP_D) begin
              op_q     <= rx_byte;
              cnt_q    <= '0;
              rx_tmr_q <= '0;
              state_q  <= RX_DATA;
            end else begin
              state_q <= SEND_NAK;
            end
          end
        end

        RX_DATA: begin
          if (rx_dv) begin
            shreg_q  <= {shreg_q[119:0], rx_byte};
            cnt_q    <= cnt_q + 4'd1;
            rx_tmr_q <= '0;
            if (cnt_q == 4'd15) begin
              cnt_q <= '0;
              if (op_q == OP_K)     state_q <= LOAD_KEY;
              else if (key_valid_q) state_q <= ISSUE;
              else                  state_q <= SEND_NAK;
            end
          end else if (rx_tmr_q == RX_LAST) begin
            state_q <= SEND_NAK;
          end else begin
            rx_tmr_q <= rx_tmr_q + 1'b1;
          end
        end

        LOAD_KEY: begin
          key_q       <= shreg_q;
          lnk_q       <= 1'b1;
          key_valid_q <= 1'b0;
          aes_tmr_q   <= '0;
          state_q     <= WAIT_KEY;
        end

        // done_key_expansion may still be high from the previous key; skip the
        // pulse cycle plus two more before trusting it.
        WAIT_KEY: begin
          if (aes_tmr_q >= KEY_SKIP && done_key_expansion) begin
            key_valid_q <= 1'b1;
            state_q     <= SEND_ACK;
          end else if (aes_tmr_q == AES_LAST) begin
            err_q   <= 1'b1;
            state_q <= SEND_NAK;
          end else begin
            aes_tmr_q <= aes_tmr_q + 1'b1;
          end
        end

        ISSUE: begin
          data_q   <= shreg_q;
          enc_iv_q <= (op_q == OP_E);
          dec_iv_q <= (op_q != OP_E);
          if (cnt_q == IV_LAST) begin
            aes_tmr_q <= '0;
            state_q   <= WAIT_RES;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        WAIT_RES: begin
          if (res_hit) begin
            shreg_q <= (op_q == OP_E) ? cipher_text_out : plain_text_out;
            cnt_q   <= '0;
            state_q <= TX_BYTE;
          end else if (aes_tmr_q == AES_LAST) begin
            err_q   <= 1'b1;
            state_q <= SEND_NAK;
          end else begin
            aes_tmr_q <= aes_tmr_q + 1'b1;
          end
        end

        TX_BYTE: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= shreg_q[127:120];
          state_q   <= TX_WAIT;
        end

        TX_WAIT: begin
          if (tx_done) begin
            if (cnt_q == 4'd15) begin
              state_q <= IDLE;
            end else begin
              shreg_q <= {shreg_q[119:0], 8'h00};
              cnt_q   <= cnt_q + 4'd1;
              state_q <= TX_BYTE;
            end
          end
        end

        SEND_ACK: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= ACK;
          state_q   <= WAIT_1;
        end

        SEND_NAK: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= NAK;
          state_q   <= WAIT_1;
        end

        WAIT_1: begin
          if (tx_done) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_dv        = tx_dv_q;
  assign tx_byte      = tx_byte_q;
  assign load_new_key = lnk_q;
  assign cipher_key   = key_q;
  assign enc_in_valid = enc_iv_q;
  assign dec_in_valid = dec_iv_q;
  assign aes_data_in  = data_q;
  assign key_valid    = key_valid_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Bench for aes_cmd_sequencer: behavioural UART/AES stand-ins plus a frame-level
// reference model predicting the response bytes, key_valid and err.
module tb_aes_cmd_sequencer;
  localparam int RXTO  = 300;
  localparam int AESTO = 200;
  localparam logic [7:0] OP_K = 8'h4B, OP_E = 8'h45, OP_D = 8'h44;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         rx_dv = 1'b0, tx_done = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         tx_dv, load_new_key, enc_in_valid, dec_in_valid, key_valid, busy, err;
  logic [7:0]   tx_byte;
  logic [127:0] cipher_key, aes_data_in;
  logic         enc_out_valid, dec_out_valid, done_key_expansion;
  logic [127:0] cipher_text_out, plain_text_out;

  aes_cmd_sequencer #(.IN_VALID_CYCLES(2), .RX_TIMEOUT(RXTO), .AES_TIMEOUT(AESTO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_byte(rx_byte), .tx_dv(tx_dv),
    .tx_byte(tx_byte), .tx_done(tx_done), .load_new_key(load_new_key),
    .cipher_key(cipher_key), .enc_in_valid(enc_in_valid), .dec_in_valid(dec_in_valid),
    .aes_data_in(aes_data_in), .enc_out_valid(enc_out_valid), .cipher_text_out(cipher_text_out),
    .dec_out_valid(dec_out_valid), .plain_text_out(plain_text_out),
    .done_key_expansion(done_key_expansion), .key_valid(key_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int key_delay = 20, res_delay = 5, tx_lat = 3;
  bit aes_silent = 0, dual = 0;
  int n_lnk = 0, enc_cyc = 0, dec_cyc = 0, viol = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  bit m_kv = 0, m_err = 0;
  logic [127:0] m_key = '0;

  function automatic logic [127:0] enc_fn(input logic [127:0] d, input logic [127:0] k);
    if (k == 128'h000102030405060708090A0B0C0D0E0F && d == 128'h00112233445566778899AABBCCDDEEFF)
      return 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    return d ^ k ^ 128'hA5A5_0F0F_3C3C_C3C3_5A5A_F0F0_1234_8765;
  endfunction

  function automatic logic [127:0] dec_fn(input logic [127:0] d, input logic [127:0] k);
    return {d[63:0], d[127:64]} ^ {k[63:0], k[127:64]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART_TX stand-in: records each byte, answers tx_done after tx_lat cycles.
  initial begin : uart_tx_model
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        tx_q.push_back(tx_byte);
        for (int i = 0; i < tx_lat; i++) begin
          @(negedge clk);
          if (tx_dv) viol++;
        end
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // AES_top stand-in.
  initial begin : aes_model
    logic [127:0] d, k;
    bit is_enc, prev;
    prev = 0;
    done_key_expansion = 0; enc_out_valid = 0; dec_out_valid = 0;
    cipher_text_out = '0; plain_text_out = '0;
    forever begin
      @(negedge clk);
      if (load_new_key) begin
        done_key_expansion = 0;
        if (!aes_silent) begin
          repeat (key_delay) @(negedge clk);
          done_key_expansion = 1;
        end
      end else if ((enc_in_valid || dec_in_valid) && !prev && !aes_silent) begin
        d = aes_data_in; k = cipher_key; is_enc = enc_in_valid;
        repeat (res_delay) @(negedge clk);
        if (dual && !is_enc) begin
          cipher_text_out = ~d; enc_out_valid = 1;
          @(negedge clk);
          enc_out_valid = 0;
          @(negedge clk);
        end
        if (is_enc) begin cipher_text_out = enc_fn(d, k); enc_out_valid = 1; end
        else begin plain_text_out = dec_fn(d, k); dec_out_valid = 1; end
        @(negedge clk);
        enc_out_valid = 0; dec_out_valid = 0;
      end
      prev = enc_in_valid || dec_in_valid;
    end
  end

  initial begin : strobe_monitor
    forever begin
      @(negedge clk);
      if (enc_in_valid) enc_cyc++;
      if (dec_in_valid) dec_cyc++;
      if (load_new_key) n_lnk++;
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_byte = b; rx_dv = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [127:0] pl, input int maxgap);
    send_byte(op, $urandom_range(0, maxgap));
    if (op == OP_K || op == OP_E || op == OP_D)
      for (int i = 0; i < 16; i++) send_byte(pl[127-8*i -: 8], $urandom_range(0, maxgap));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    chk({tag, " idle"}, busy, 1'b0);
  endtask

  task automatic expect_resp(input string tag);
    chk({tag, " len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), tx_q[i], exp_q[i]);
    tx_q.delete(); exp_q.delete();
  endtask

  // Frame-level reference: what the link must answer for one command.
  task automatic predict(input logic [7:0] op, input logic [127:0] pl);
    logic [127:0] r;
    exp_q.delete();
    if (op == OP_K) begin
      if (aes_silent) begin exp_q.push_back(8'h15); m_kv = 0; m_err = 1; end
      else begin exp_q.push_back(8'h06); m_kv = 1; m_key = pl; end
    end else if (op == OP_E || op == OP_D) begin
      if (!m_kv) exp_q.push_back(8'h15);
      else if (aes_silent) begin exp_q.push_back(8'h15); m_err = 1; end
      else begin
        r = (op == OP_E) ? enc_fn(pl, m_key) : dec_fn(pl, m_key);
        for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
      end
    end else begin
      exp_q.push_back(8'h15);
    end
  endtask

  task automatic do_cmd(input logic [7:0] op, input logic [127:0] pl, input int maxgap, input string tag);
    predict(op, pl);
    enc_cyc = 0; dec_cyc = 0; n_lnk = 0;
    send_frame(op, pl, maxgap);
    wait_idle(tag);
    expect_resp(tag);
    chk({tag, " key_valid"}, key_valid, m_kv);
    chk({tag, " err"}, err, m_err);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : main
    logic [7:0] op, b;
    int r;
    repeat (3) @(negedge clk);
    chk("rst tx_dv", tx_dv, 0);          chk("rst tx_byte", tx_byte, 0);
    chk("rst load_new_key", load_new_key, 0); chk("rst cipher_key", cipher_key, 0);
    chk("rst enc_in_valid", enc_in_valid, 0); chk("rst dec_in_valid", dec_in_valid, 0);
    chk("rst aes_data_in", aes_data_in, 0);   chk("rst key_valid", key_valid, 0);
    chk("rst busy", busy, 0);                 chk("rst err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmd(OP_E, rnd128(), 2, "e_nokey");
    chk("e_nokey enc cycles", enc_cyc, 0);
    do_cmd(8'h7A, '0, 0, "badop");

    exp_q.delete();
    send_byte(OP_K, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h30), 1);
    repeat (RXTO - 20) @(negedge clk);
    chk("rxto still busy", busy, 1);
    chk("rxto no tx yet", tx_q.size(), 0);
    wait_idle("rxto");
    exp_q.push_back(8'h15);
    expect_resp("rxto");
    chk("rxto key_valid", key_valid, 0);

    key_delay = 20;
    do_cmd(OP_K, 128'h000102030405060708090A0B0C0D0E0F, 0, "key");
    chk("key lnk pulses", n_lnk, 1);
    chk("key cipher_key", cipher_key, 128'h000102030405060708090A0B0C0D0E0F);

    res_delay = 5;
    do_cmd(OP_E, 128'h00112233445566778899AABBCCDDEEFF, 1, "enc");
    chk("enc iv cycles", enc_cyc, 2);
    chk("enc no dec iv", dec_cyc, 0);
    chk("enc aes_data_in", aes_data_in, 128'h00112233445566778899AABBCCDDEEFF);

    dual = 1;
    do_cmd(OP_D, rnd128(), 1, "dec_dual");
    chk("dec iv cycles", dec_cyc, 2);
    chk("dec no enc iv", enc_cyc, 0);
    dual = 0;

    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) op = OP_K;
      else if (r < 6) op = OP_E;
      else if (r < 9) op = OP_D;
      else begin
        do b = 8'($urandom); while (b == OP_K || b == OP_E || b == OP_D);
        op = b;
      end
      key_delay = $urandom_range(3, 40);
      res_delay = $urandom_range(3, 40);
      tx_lat = $urandom_range(1, 6);
      dual = bit'($urandom_range(0, 1));
      do_cmd(op, rnd128(), 5, $sformatf("rnd%0d", n));
    end
    dual = 0; tx_lat = 3; key_delay = 10; res_delay = 5;

    do_cmd(OP_K, rnd128(), 0, "key2");
    aes_silent = 1;
    do_cmd(OP_E, rnd128(), 0, "enc_silent");
    do_cmd(OP_K, rnd128(), 0, "key_silent");
    aes_silent = 0;
    do_cmd(OP_E, rnd128(), 0, "enc_after_badkey");
    chk("enc_after_badkey iv", enc_cyc, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_kv = 0; m_err = 0;
    do_cmd(OP_K, rnd128(), 0, "key3");
    send_frame(OP_E, rnd128(), 0);
    for (int i = 0; i < 2000 && tx_q.size() < 3; i++) @(negedge clk);
    chk("midtx reached", tx_q.size() >= 3, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);          chk("midrst tx_dv", tx_dv, 0);
    chk("midrst key_valid", key_valid, 0); chk("midrst err", err, 0);
    chk("midrst cipher_key", cipher_key, 0); chk("midrst aes_data_in", aes_data_in, 0);
    chk("midrst enc_iv", enc_in_valid, 0); chk("midrst lnk", load_new_key, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tx_q.delete();
    m_kv = 0; m_err = 0;

    do_cmd(OP_K, rnd128(), 0, "key4");
    predict(OP_E, 128'hFEDCBA98765432100123456789ABCDEF);
    send_frame(OP_E, 128'hFEDCBA98765432100123456789ABCDEF, 0);
    for (int i = 0; i < 2000 && tx_q.size() < 2; i++) @(negedge clk);
    chk("droptx reached", tx_q.size() >= 2, 1);
    send_byte(8'hA5, 0);
    wait_idle("droptx");
    expect_resp("droptx");
    chk("droptx err", err, 1);

    chk("tx_dv while outstanding", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
